fifo_wr_arbiter: RTL and testbench

//  Shares one synchronous FIFO write port (8-bit, 64-deep) between N producers.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 103 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEFAULT = 8;
    localparam int FIFO_DEPTH     = 64;
    localparam int BEAT_W         = 8;

    // (base + off) mod n, for base < n and off <= n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after rr_ptr wins.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any_req
);

    localparam int IDX_W = $clog2(N_REQ);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Scan rr_ptr, rr_ptr+1, ... with wrap; the first hit is the winner.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        winner  = rr_ptr;
        any_req = |req;
        found   = 1'b0;
        idx     = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'(wrap_add(int'(rr_ptr), k, N_REQ));
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// A winner keeps the port for up to MAX_BURST accepted words; the FIFO's
// full flag stalls the owner without dropping ownership.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    fifo_wr_en,
    output logic [DATA_W-1:0]       fifo_buf_in,
    input  logic                    fifo_buf_full
);

    localparam int                IDX_W     = $clog2(N_REQ);
    localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(MAX_BURST);

    arb_state_e        state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  winner;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_next;
    logic              any_req;
    logic              owner_req;
    logic              owner_last;
    logic              accept;
    logic              burst_done;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Word acceptance, ack fan-out, FIFO drive and end-of-burst detection.
    always_comb begin
        owner_req   = req[owner];
        owner_last  = req_last[owner];
        // A word presented during reset is never acked: ownership is being dropped.
        accept      = (state == BURST) && owner_req && !fifo_buf_full && !rst;
        beat_next   = (beat_cnt >= MAX_BEATS) ? beat_cnt : beat_cnt + BEAT_W'(1);
        burst_done  = (state == BURST) &&
                      (!owner_req || (accept && (owner_last || (beat_next == MAX_BEATS))));
        ack         = grant & {N_REQ{accept}};
        fifo_wr_en  = accept;
        fifo_buf_in = (grant != '0) ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
    end

    // Arbitration FSM with registered grant/busy, beat counter and rotation pointer.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= BURST;
                        grant    <= N_REQ'(1) << winner;
                        owner    <= winner;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_next;
                    end
                    if (burst_done) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= IDX_W'(wrap_add(int'(owner), 1, N_REQ));
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: arbiter in front of a 64-deep FIFO model, four producers.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MB   = 8;
    localparam int LOGN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            busy;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_buf_in;
    logic            fifo_buf_full;
    logic            rd_en;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .req_last      (req_last),
        .ack           (ack),
        .grant         (grant),
        .busy          (busy),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_buf_in   (fifo_buf_in),
        .fifo_buf_full (fifo_buf_full)
    );

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] last_pop;
    int            remain[N];
    int            seq[N];
    logic          use_last[N];

    logic [N-1:0]  grant_log[LOGN];
    logic [N-1:0]  ack_log[LOGN];
    logic          busy_log[LOGN];
    logic          wr_log[LOGN];
    logic [1:0]    rr_log[LOGN];
    logic [DW-1:0] data_log[LOGN];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int i, input int s);
        return DW'(i * 64 + 16 + s);
    endfunction

    // Producer and FIFO-flag drive from the bench model.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]               = (remain[i] > 0);
            req_last[i]          = use_last[i] && (remain[i] == 1);
            req_data[i*DW +: DW] = word_of(i, seq[i]);
        end
        fifo_buf_full = (fifo_q.size() >= FIFO_DEPTH);
    endtask

    // One cycle: sample on negedge, update FIFO/producer models after posedge.
    task automatic tick(input int c);
        logic [N-1:0]  s_ack;
        logic          s_wr;
        logic          s_full;
        logic          s_rd;
        logic [DW-1:0] s_data;
        @(negedge clk);
        s_ack  = ack;
        s_wr   = fifo_wr_en;
        s_full = fifo_buf_full;
        s_rd   = rd_en;
        s_data = fifo_buf_in;
        if (c >= 0 && c < LOGN) begin
            grant_log[c] = grant;
            ack_log[c]   = ack;
            busy_log[c]  = busy;
            wr_log[c]    = fifo_wr_en;
            rr_log[c]    = dut.rr_ptr;
            data_log[c]  = fifo_buf_in;
        end
        @(posedge clk);
        #1;
        if (s_wr && !s_full) fifo_q.push_back(s_data);
        if (s_rd && fifo_q.size() > 0) last_pop = fifo_q.pop_front();
        for (int i = 0; i < N; i++) begin
            if (s_ack[i]) begin
                seq[i]++;
                remain[i]--;
            end
        end
        drive();
    endtask

    task automatic run(input int n, input int rd_at, input int rst_at);
        for (int c = 0; c < n; c++) begin
            rd_en = (c == rd_at);
            rst   = (c == rst_at);
            tick(c);
        end
        rd_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            remain[i]   = 0;
            seq[i]      = 0;
            use_last[i] = 1'b0;
        end
        rd_en = 1'b0;
        rst   = 1'b1;
        drive();
        tick(-1);
        tick(-1);
        rst = 1'b0;
        fifo_q.delete();
        drive();
    endtask

    initial begin
        int n;

        // Reset state
        do_reset();
        run(1, -1, -1);
        check("rst_grant", grant_log[0], 0);
        check("rst_busy", busy_log[0], 0);
        check("rst_ack", ack_log[0], 0);
        check("rst_wr_en", wr_log[0], 0);
        check("rst_buf_in", data_log[0], 0);
        check("rst_rr_ptr", rr_log[0], 0);

        // 1: single producer, three words, last on the third
        do_reset();
        remain[0] = 3; use_last[0] = 1'b1; drive();
        run(6, -1, -1);
        check("t1_idle_ack", ack_log[0], 0);
        check("t1_idle_grant", grant_log[0], 0);
        check("t1_grant", grant_log[1], 4'b0001);
        check("t1_busy", busy_log[1], 1);
        for (int c = 1; c <= 3; c++) check($sformatf("t1_ack%0d", c), ack_log[c], 4'b0001);
        check("t1_data0", data_log[1], word_of(0, 0));
        check("t1_data2", data_log[3], word_of(0, 2));
        check("t1_end_ack", ack_log[4], 0);
        check("t1_end_grant", grant_log[4], 0);
        check("t1_end_busy", busy_log[4], 0);
        check("t1_rr_ptr", rr_log[4], 1);
        check("t1_fifo_cnt", fifo_q.size(), 3);
        for (int j = 0; j < 3; j++) check($sformatf("t1_fifo%0d", j), fifo_q[j], word_of(0, j));

        // 2: all four requesting, no last; MAX_BURST bursts, rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) remain[i] = 100;
        drive();
        run(40, -1, -1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_grant%0d", k), grant_log[1 + 9*k], 4'b0001 << (k % 4));
        end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            for (int c = 1 + 9*k; c <= 8 + 9*k; c++) if (ack_log[c] == (4'b0001 << k)) n++;
            check($sformatf("t2_acks%0d", k), n, MB);
            check($sformatf("t2_bubble_grant%0d", k), grant_log[9 + 9*k], 0);
            check($sformatf("t2_bubble_ack%0d", k), ack_log[9 + 9*k], 0);
        end
        check("t2_fifo_cnt", fifo_q.size(), 35);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < MB; j++)
                check($sformatf("t2_fifo_p%0d_w%0d", i, j), fifo_q[8*i + j], word_of(i, j));

        // 3: FIFO fills mid-burst, stall, one read frees exactly one slot
        do_reset();
        repeat (60) fifo_q.push_back(8'hEE);
        remain[2] = 8; use_last[2] = 1'b1; drive();
        run(16, 10, -1);
        check("t3_grant", grant_log[1], 4'b0100);
        for (int c = 5; c <= 10; c++) begin
            check($sformatf("t3_stall_ack%0d", c), ack_log[c], 0);
            check($sformatf("t3_stall_wr%0d", c), wr_log[c], 0);
            check($sformatf("t3_stall_grant%0d", c), grant_log[c], 4'b0100);
        end
        check("t3_extra_ack", ack_log[11], 4'b0100);
        for (int c = 12; c <= 15; c++) begin
            check($sformatf("t3_refull_ack%0d", c), ack_log[c], 0);
            check($sformatf("t3_refull_grant%0d", c), grant_log[c], 4'b0100);
        end
        n = 0;
        for (int c = 0; c < 16; c++) if (ack_log[c] != 0) n++;
        check("t3_total_acks", n, 5);
        check("t3_fifo_cnt", fifo_q.size(), FIFO_DEPTH);
        check("t3_popped", last_pop, 8'hEE);
        check("t3_fifo58", fifo_q[58], 8'hEE);
        for (int j = 0; j < 5; j++) check($sformatf("t3_fifo%0d", 59 + j), fifo_q[59 + j], word_of(2, j));

        // 4: owner releases after two words; next requester after bubble
        do_reset();
        remain[1] = 2;
        remain[3] = 1; use_last[3] = 1'b1;
        drive();
        run(8, -1, -1);
        check("t4_grant", grant_log[1], 4'b0010);
        check("t4_ack1", ack_log[1], 4'b0010);
        check("t4_ack2", ack_log[2], 4'b0010);
        check("t4_release_ack", ack_log[3], 0);
        check("t4_release_grant", grant_log[3], 4'b0010);
        check("t4_bubble_grant", grant_log[4], 0);
        check("t4_bubble_busy", busy_log[4], 0);
        check("t4_rr_ptr", rr_log[4], 2);
        check("t4_next_grant", grant_log[5], 4'b1000);
        check("t4_next_ack", ack_log[5], 4'b1000);
        check("t4_rr_wrap", rr_log[6], 0);
        check("t4_fifo_cnt", fifo_q.size(), 3);
        check("t4_fifo2", fifo_q[2], word_of(3, 0));

        // 5: reset mid-burst drops ownership; re-arbitration from producer 0
        do_reset();
        remain[0] = 10; remain[1] = 10; drive();
        run(8, -1, 3);
        check("t5_ack2", ack_log[2], 4'b0001);
        check("t5_rst_ack", ack_log[3], 0);
        check("t5_rst_wr", wr_log[3], 0);
        check("t5_post_grant", grant_log[4], 0);
        check("t5_post_busy", busy_log[4], 0);
        check("t5_post_ack", ack_log[4], 0);
        check("t5_post_rr", rr_log[4], 0);
        check("t5_regrant", grant_log[5], 4'b0001);
        check("t5_redata", data_log[5], word_of(0, 2));
        check("t5_fifo_cnt", fifo_q.size(), 5);
        for (int j = 0; j < 5; j++) check($sformatf("t5_fifo%0d", j), fifo_q[j], word_of(0, j));

        // 6: last on the MAX_BURST-th word ends the burst once
        do_reset();
        remain[0] = 8; use_last[0] = 1'b1;
        remain[1] = 3; use_last[1] = 1'b1;
        remain[2] = 1; use_last[2] = 1'b1;
        drive();
        run(16, -1, -1);
        n = 0;
        for (int c = 1; c <= 8; c++) if (ack_log[c] == 4'b0001) n++;
        check("t6_acks0", n, MB);
        check("t6_bubble_grant", grant_log[9], 0);
        check("t6_rr_ptr", rr_log[9], 1);
        check("t6_next_grant", grant_log[10], 4'b0010);
        check("t6_rr_ptr2", rr_log[13], 2);
        check("t6_third_grant", grant_log[14], 4'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
